multiphase_clk_gen: RTL and testbench
=====================================

# multiphase_clk_gen

Parametrised multi-phase clock divider with sequenced reset release. It derives NUM_PHASES divided clocks from clk_i, all with period 2·div_i input cycles, with phase k lagging phase 0 by k·step_i input cycles. For each phase it generates an active-low reset, released once the clock has run RST_HOLD full periods. It generalises the fixed 0°/90° divide-by-2 generator: ratio and offset are programmable, phase count is a parameter, and it supports a glitch-free stop and configuration checking.

## Interface
- NUM_PHASES, default 4: number of phase outputs, at least 1.
- DIV_W, default 8: width of div_i, step_i and the phase counter.
- RST_HOLD, default 2: number of full phase-0 periods before reset release, at least 1.
- INIT, default 1'b0: idle/reset level of every phase output.
- clk_i, input, 1: the single clock.
- rst_i, input, 1: reset; asynchronous, active-low.
- en_i, input, 1: run request; level-sensitive.
- div_i, input, DIV_W: half-period in clk_i cycles; sampled only at start.
- step_i, input, DIV_W: phase-to-phase offset in cycles; sampled only at start.
- phase_o, output, NUM_PHASES: divided clocks; bit k is phase k.
- rst_o, output, NUM_PHASES: per-phase active-low reset.
- locked_o, output, 1: high when all rst_o bits are high.
- cfg_err_o, output, 1: configuration rejected at the last start attempt.

## Operation
- States:
  - IDLE: outputs parked.
  - WARM: phases toggling, resets held.
  - RUN: resets released progressively.
  - STOP: phases draining back to INIT.
- Reset (async, rst_i=0) values:
  - state=IDLE, cnt=0
  - phase_o={NUM_PHASES{INIT}}
  - rst_o=0, locked_o=0, cfg_err_o=0
- IDLE → WARM: en_i=1 and configuration valid. Valid means div_i≠0 and step_i·(NUM_PHASES−1) < div_i, with the product computed in DIV_W+$clog2(NUM_PHASES) bits (no truncation). On this edge:
  - latch div_q and step_q
  - cnt←0
  - cfg_err_o←0
- Invalid configuration with en_i=1: cfg_err_o←1 and the block stays in IDLE. It re-evaluates each cycle, so correcting the inputs while en_i stays high starts the block.
- Counter: while not in IDLE, cnt wraps as 0…div_q−1.
- Toggle rule: phase k toggles on any edge with cnt==k·step_q.
- Period end: cnt==div_q−1 and phase_o[0]==INIT. In WARM, count period ends; on the RST_HOLD-th one, go to RUN.
- RUN: rst_o[k]←1 on the first edge in RUN at which phase k toggles from INIT to ~INIT. locked_o is registered: it rises the cycle after the last rst_o bit is set.
- WARM/RUN → STOP: on the edge sampling en_i=0. On that same edge, rst_o←0 and locked_o←0.
- STOP:
  - phase k toggles only if it currently equals ~INIT, so no phase starts a new half-period
  - go to IDLE when all phases equal INIT
  - no high or low pulse shorter than div_q cycles may be produced
- Ignored inputs:
  - en_i during STOP is ignored. If en_i is still high on reaching IDLE, the normal start applies on the next edge.
  - div_i and step_i are ignored outside IDLE.

## Timing
- Take start edge E0 as the IDLE→WARM edge. Phase k first toggles at edge E(1+k·step_q). Every subsequent toggle follows 2·... no: every subsequent toggle follows div_q edges later, giving period 2·div_q.
- step_q=0: all phases are identical. div_q=1: phase_o toggles every cycle (divide by 2).
- Reset release: rst_o[0] rises at E(1+2·div_q·RST_HOLD); rst_o[k] rises k·step_q cycles later.
- Stop latency: at most 2·div_q cycles from the en_i=0 sample to IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package multiphase_clk_gen_pkg holds:
  - the state enum (IDLE, WARM, RUN, STOP)
  - a cfg_t struct {div, step} parametrised via DIV_W in the package
- Sub-module multiphase_clk_phase holds one phase's toggle flop and rst_o flop. Inputs: toggle strobe, stop gating, run flag. It is instantiated NUM_PHASES times through a generate loop.
- The top level holds the FSM, cnt, the period counter ($clog2(RST_HOLD+1) bits) and the validity check.

## Test plan
- N=4, div=8, step=2, INIT=0, RST_HOLD=2, en_i=1:
  - phase k first rises at E(1+2k)
  - period is 16 for every phase
  - rst_o[0] rises at E33, rst_o[3] at E39
  - locked_o rises at E40
- N=2, div=1, step=0: both phases toggle every cycle and stay identical; reset release follows at E5.
- N=4, div=4, step=2: 6≥4 → cfg_err_o=1 and phase_o stays 0. Then set step=1 while en_i stays high → start, and cfg_err_o clears.
- Stop in RUN (div=8, step=2):
  - rst_o and locked_o drop on the next edge
  - each phase finishes its high half (8 cycles); no pulse is shorter than 8
  - IDLE within 16 cycles
  - en_i pulsed during STOP has no effect
- Async reset mid-RUN: phase_o, rst_o and locked_o reach reset values with no clk_i edge. After release with en_i=1, the start sequence matches test 1.
- div_i changed from 8 to 3 during RUN: period stays 16 until a stop and restart. After restart, the period is 6.

Source files
------------

// File: rtl/multiphase_clk_gen_pkg.sv
// Shared types for the multi-phase clock generator: FSM states and the
// configuration latched at each start.
package multiphase_clk_gen_pkg;

  // Width of the stored configuration; the top-level DIV_W defaults to this and must not exceed it.
  localparam int unsigned CfgDivW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWarm,
    StRun,
    StStop
  } state_e;

  typedef struct packed {
    logic [CfgDivW-1:0] div;
    logic [CfgDivW-1:0] step;
  } cfg_t;

endpackage

// File: rtl/multiphase_clk_phase.sv
// One divided-clock phase: the toggle flop plus its sticky active-low reset
// output, released on the first rising half-period seen while running.
module multiphase_clk_phase #(
  parameter logic INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  input  logic stop_i,
  input  logic run_i,
  input  logic clr_i,
  output logic phase_o,
  output logic rst_o
);

  logic phase_q;
  logic rst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= INIT;
      rst_q   <= 1'b0;
    end else begin
      // While stopping, only the return to INIT is allowed, so a half-period is never started.
      if (tgl_i && (!stop_i || (phase_q != INIT))) begin
        phase_q <= ~phase_q;
      end
      if (clr_i) begin
        rst_q <= 1'b0;
      end else if (run_i && tgl_i && (phase_q == INIT)) begin
        rst_q <= 1'b1;
      end
    end
  end

  assign phase_o = phase_q;
  assign rst_o   = rst_q;

endmodule

// File: rtl/multiphase_clk_gen.sv
// Multi-phase clock divider: NUM_PHASES clocks of period 2*div, each lagging the
// previous by step cycles, with per-phase reset release and a glitch-free stop.
module multiphase_clk_gen
  import multiphase_clk_gen_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned DIV_W      = CfgDivW,
  parameter int unsigned RST_HOLD   = 2,
  parameter logic        INIT       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic [DIV_W-1:0]      step_i,
  output logic [NUM_PHASES-1:0] phase_o,
  output logic [NUM_PHASES-1:0] rst_o,
  output logic                  locked_o,
  output logic                  cfg_err_o
);

  localparam int unsigned ProdW = DIV_W + $clog2(NUM_PHASES);
  localparam int unsigned PerW  = $clog2(RST_HOLD + 1);

  state_e            state_q;
  cfg_t              cfg_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [PerW-1:0]   per_q;
  logic              locked_q;
  logic              cfg_err_q;

  logic [DIV_W-1:0]      div_lat;
  logic [DIV_W-1:0]      step_lat;
  logic                  cfg_ok;
  logic                  cnt_wrap;
  logic                  period_end;
  logic                  all_init;
  logic                  active;
  logic                  stop_req;
  logic [NUM_PHASES-1:0] tgl;

  assign div_lat  = DIV_W'(cfg_q.div);
  assign step_lat = DIV_W'(cfg_q.step);

  // Widened product so the last phase offset can never wrap into range.
  assign cfg_ok = (div_i != '0) &&
                  ((ProdW'(step_i) * ProdW'(NUM_PHASES - 1)) < ProdW'(div_i));

  assign cnt_wrap   = (cnt_q == (div_lat - DIV_W'(1)));
  assign all_init   = (phase_o == {NUM_PHASES{INIT}});
  assign period_end = cnt_wrap && (phase_o[0] == INIT);
  assign active     = (state_q != StIdle);
  assign stop_req   = ((state_q == StWarm) || (state_q == StRun)) && !en_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cfg_q     <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      if (active) begin
        cnt_q <= cnt_wrap ? '0 : cnt_q + DIV_W'(1);
      end
      locked_q <= stop_req ? 1'b0 : &rst_o;

      unique case (state_q)
        StIdle: begin
          if (en_i) begin
            if (cfg_ok) begin
              state_q    <= StWarm;
              cfg_q.div  <= CfgDivW'(div_i);
              cfg_q.step <= CfgDivW'(step_i);
              cnt_q      <= '0;
              per_q      <= '0;
              cfg_err_q  <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StWarm: begin
          if (!en_i) begin
            state_q <= StStop;
          end else if (period_end) begin
            if (per_q == PerW'(RST_HOLD - 1)) begin
              state_q <= StRun;
            end else begin
              per_q <= per_q + PerW'(1);
            end
          end
        end
        StRun: begin
          if (!en_i) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          // Leave on a counter wrap so a prompt restart cannot shorten the final low half.
          if (all_init && cnt_wrap) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
    assign tgl[k] = active && (ProdW'(cnt_q) == (ProdW'(k) * ProdW'(step_lat)));

    multiphase_clk_phase #(
      .INIT (INIT)
    ) u_phase (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .tgl_i   (tgl[k]),
      .stop_i  (state_q == StStop),
      .run_i   (state_q == StRun),
      .clr_i   (stop_req),
      .phase_o (phase_o[k]),
      .rst_o   (rst_o[k])
    );
  end

  assign locked_o  = locked_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Directed bench for multiphase_clk_gen: closed-form expectations per cycle are
// queued on a scoreboard and compared against both a 4-phase and a 2-phase instance.
module tb_multiphase_clk_gen;

  localparam int Hold = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en4, en2;
  logic [7:0] div4, step4, div2, step2;
  logic [3:0] ph4, rs4;
  logic       lk4, er4;
  logic [1:0] ph2, rs2;
  logic       lk2, er2;

  always #5 clk = ~clk;

  multiphase_clk_gen #(
    .NUM_PHASES (4),
    .DIV_W      (8),
    .RST_HOLD   (Hold),
    .INIT       (1'b0)
  ) dut4 (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .en_i      (en4),
    .div_i     (div4),
    .step_i    (step4),
    .phase_o   (ph4),
    .rst_o     (rs4),
    .locked_o  (lk4),
    .cfg_err_o (er4)
  );

  multiphase_clk_gen #(
    .NUM_PHASES (2),
    .DIV_W      (8),
    .RST_HOLD   (Hold),
    .INIT       (1'b0)
  ) dut2 (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .en_i      (en2),
    .div_i     (div2),
    .step_i    (step2),
    .phase_o   (ph2),
    .rst_o     (rs2),
    .locked_o  (lk2),
    .cfg_err_o (er2)
  );

  typedef struct packed {
    logic [3:0] ph;
    logic [3:0] rs;
    logic       lk;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Phase k toggles at edges 1+k*s, 1+k*s+d, ... counted from the start edge E0.
  function automatic logic exp_ph(input int j, input int k, input int d, input int s);
    int f;
    f = 1 + k * s;
    if (j < f) return 1'b0;
    return (((j - f) / d) % 2) == 0;
  endfunction

  function automatic logic [3:0] exp_phv(input int j, input int n, input int d, input int s);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = exp_ph(j, k, d, s);
    return v;
  endfunction

  function automatic logic [3:0] exp_rsv(input int j, input int n, input int d, input int s);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = (j >= 1 + 2 * d * Hold + k * s);
    return v;
  endfunction

  function automatic logic exp_lk(input int j, input int n, input int d, input int s);
    return j >= 2 + 2 * d * Hold + (n - 1) * s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp4(input string tag, input int j);
    exp_t e;
    e = sb.pop_front();
    chk($sformatf("%s_phase j=%0d", tag, j), ph4, e.ph);
    chk($sformatf("%s_rst j=%0d", tag, j), rs4, e.rs);
    chk($sformatf("%s_locked j=%0d", tag, j), lk4, e.lk);
    chk($sformatf("%s_cfg_err j=%0d", tag, j), er4, e.er);
  endtask

  task automatic run4(input string tag, input int j0, input int j1, input int d, input int s);
    for (int j = j0; j <= j1; j++) begin
      exp_t e;
      e.ph = exp_phv(j, 4, d, s);
      e.rs = exp_rsv(j, 4, d, s);
      e.lk = exp_lk(j, 4, d, s);
      e.er = 1'b0;
      sb.push_back(e);
      tick();
      pop_cmp4(tag, j);
    end
  endtask

  // Drop en at edge js; a high phase finishes its half-period, then stays low.
  task automatic stop4(input string tag, input int js, input int d, input int s,
                       input int ncyc, input int pulse);
    logic [3:0] done;
    done = '0;
    en4  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      exp_t       e;
      logic [3:0] f;
      if (i == pulse) en4 = 1'b1;
      if (i == pulse + 2) en4 = 1'b0;
      f = exp_phv(js + i, 4, d, s);
      for (int k = 0; k < 4; k++) begin
        if (done[k]) f[k] = 1'b0;
        else if (!f[k]) done[k] = 1'b1;
      end
      e.ph = f;
      e.rs = '0;
      e.lk = 1'b0;
      e.er = 1'b0;
      sb.push_back(e);
      tick();
      pop_cmp4(tag, js + i);
    end
    en4 = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b1;
    en4   = 1'b0;
    en2   = 1'b0;
    div4  = 8'd8;
    step4 = 8'd2;
    div2  = 8'd1;
    step2 = 8'd0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_phase4", ph4, 4'h0);
    chk("reset_rst4", rs4, 4'h0);
    chk("reset_locked4", lk4, 1'b0);
    chk("reset_cfg_err4", er4, 1'b0);
    chk("reset_phase2", ph2, 2'h0);
    chk("reset_rst2", rs2, 2'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_phase4", ph4, 4'h0);

    // step*3 = 6 >= div 4: rejected, stays parked.
    div4  = 8'd4;
    step4 = 8'd2;
    en4   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("cfg_err_flag c=%0d", i), er4, 1'b1);
      chk($sformatf("cfg_err_phase c=%0d", i), ph4, 4'h0);
      chk($sformatf("cfg_err_rst c=%0d", i), rs4, 4'h0);
    end
    step4 = 8'd1;
    run4("cfg_fix", 0, 25, 4, 1);
    stop4("cfg_stop", 26, 4, 1, 12, -1);

    div4  = 8'd8;
    step4 = 8'd2;
    en4   = 1'b1;
    run4("main", 0, 60, 8, 2);
    stop4("stop", 61, 8, 2, 20, 1);

    en4 = 1'b1;
    run4("pre_arst", 0, 45, 8, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", ph4, 4'h0);
    chk("arst_rst", rs4, 4'h0);
    chk("arst_locked", lk4, 1'b0);
    chk("arst_cfg_err", er4, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run4("restart", 0, 20, 8, 2);
    div4 = 8'd3;
    run4("div_ignored", 21, 45, 8, 2);
    stop4("stop2", 46, 8, 2, 20, -1);
    step4 = 8'd0;
    en4   = 1'b1;
    run4("div3", 0, 30, 3, 0);

    en2 = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      exp_t got;
      e.ph = exp_phv(j, 2, 1, 0);
      e.rs = exp_rsv(j, 2, 1, 0);
      e.lk = exp_lk(j, 2, 1, 0);
      e.er = 1'b0;
      sb.push_back(e);
      tick();
      got = sb.pop_front();
      chk($sformatf("div1_phase j=%0d", j), {30'd0, ph2}, {28'd0, got.ph});
      chk($sformatf("div1_rst j=%0d", j), {30'd0, rs2}, {28'd0, got.rs});
      chk($sformatf("div1_locked j=%0d", j), lk2, got.lk);
      chk($sformatf("div1_same j=%0d", j), ph2[1], ph2[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
